// File: rtl/stopwatch_input_cond.sv
// Button/switch conditioning for the stopwatch: 2-FF sync, per-input debounce, press pulses.
// Optional feature macro PAUSE_TOGGLE_EN: pause toggles per press instead of following the button.
module stopwatch_input_cond #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_pause,
    input  logic btn_rst,
    input  logic sw_sel,
    input  logic sw_adj,
    output logic sel,
    output logic adj,
    output logic pause,
    output logic rst_req
);

    localparam int unsigned      CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam int               NUM_IN  = 4;

    localparam int CH_PAUSE = 0;
    localparam int CH_RST   = 1;
    localparam int CH_SEL   = 2;
    localparam int CH_ADJ   = 3;

    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] r_meta;
    logic [NUM_IN-1:0] r_sync;
    logic [NUM_IN-1:0] r_db;
    logic [CNT_W-1:0]  r_cnt [NUM_IN];

    assign w_raw = {sw_adj, sw_sel, btn_rst, btn_pause};

    // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two real flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    // A new level is accepted only after DEB_CYCLES consecutive mismatching samples;
    // any matching sample restarts the count, and the count never passes CNT_MAX.
    // NOTE: the counter array is reset explicitly so a reset mid-debounce discards the partial count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (r_sync[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] < CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else begin
                    r_db[i]  <= r_sync[i];
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    logic r_rst_d;
    logic r_rst_req;
    logic w_rst_rise;

    assign w_rst_rise = r_db[CH_RST] & ~r_rst_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_d   <= 1'b0;
            r_rst_req <= 1'b0;
        end else begin
            r_rst_d   <= r_db[CH_RST];
            r_rst_req <= w_rst_rise;
        end
    end

`ifdef PAUSE_TOGGLE_EN
    logic r_pause_d;
    logic r_pstate;
    logic w_pause_press;

    assign w_pause_press = r_db[CH_PAUSE] & ~r_pause_d;

    // Reset request beats a simultaneous pause press so the stopwatch restarts running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pause_d <= 1'b0;
            r_pstate  <= 1'b0;
        end else begin
            r_pause_d <= r_db[CH_PAUSE];
            if (w_rst_rise) begin
                r_pstate <= 1'b0;
            end else if (w_pause_press) begin
                r_pstate <= ~r_pstate;
            end
        end
    end

    assign pause = r_pstate;
`else
    assign pause = r_db[CH_PAUSE];
`endif

    assign sel     = r_db[CH_SEL];
    assign adj     = r_db[CH_ADJ];
    assign rst_req = r_rst_req;

endmodule

// File: tb/tb_stopwatch_input_cond.sv
// Self-checking bench for stopwatch_input_cond with DEB_CYCLES=4: vector table,
// hand-written latency/corner sequences, and random stimulus against a window-based model.
module tb_stopwatch_input_cond;

    localparam int DEB = 4;
`ifdef PAUSE_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic btn_pause = 1'b0;
    logic btn_rst   = 1'b0;
    logic sw_sel    = 1'b0;
    logic sw_adj    = 1'b0;
    logic sel, adj, pause, rst_req;

    int n_checks = 0;
    int n_pass   = 0;

    stopwatch_input_cond #(.DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_pause (btn_pause),
        .btn_rst   (btn_rst),
        .sw_sel    (sw_sel),
        .sw_adj    (sw_adj),
        .sel       (sel),
        .adj       (adj),
        .pause     (pause),
        .rst_req   (rst_req)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted when the DEB most recent synchronised samples
    // (raw samples delayed by two edges) all disagree with the current accepted level.
    localparam logic [15:0] WIN_MASK = 16'((1 << DEB) - 1);
    logic [15:0] m_hist [4];
    logic [3:0]  m_db;
    logic [3:0]  m_db_d;
    logic        m_rst_req;
    logic        m_pstate;
    logic        m_pause;
    logic [3:0]  w_raw;

    assign w_raw   = {sw_adj, sw_sel, btn_rst, btn_pause};
    assign m_pause = TOGGLE ? m_pstate : m_db[0];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) m_hist[c] <= '0;
            m_db      <= '0;
            m_db_d    <= '0;
            m_rst_req <= 1'b0;
            m_pstate  <= 1'b0;
        end else begin
            m_rst_req <= m_db[1] & ~m_db_d[1];
            if (m_db[1] & ~m_db_d[1])      m_pstate <= 1'b0;
            else if (m_db[0] & ~m_db_d[0]) m_pstate <= ~m_pstate;
            m_db_d <= m_db;
            for (int c = 0; c < 4; c++) begin
                if (((m_hist[c] >> 1) & WIN_MASK) == (m_db[c] ? 16'h0 : WIN_MASK))
                    m_db[c] <= ~m_db[c];
                m_hist[c] <= {m_hist[c][14:0], w_raw[c]};
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " sel"},     sel,     1'b0);
        check({name, " adj"},     adj,     1'b0);
        check({name, " pause"},   pause,   1'b0);
        check({name, " rst_req"}, rst_req, 1'b0);
    endtask

    task automatic set_raw(input logic [3:0] v);
        {sw_adj, sw_sel, btn_rst, btn_pause} = v;
    endtask

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        set_raw(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] raw;        // {adj, sel, rst, pause}
        int         hold;
        logic       sel;
        logic       adj;
        logic       pause_tog;
        logic       pause_lvl;
        logic       rst_req;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded 2000000 ns limit");
        $fatal(1);
    end

    initial begin
        logic seen;

        vecs[0]  = '{4'b0100, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1100, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b1000,  3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b1100, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b1101, 10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{4'b1100, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'b1101, 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'b1100, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1110, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0000, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0001, 10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{4'b0011, 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{4'b0000, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'b0100,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'b0100,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Power-on reset
        repeat (3) @(negedge clk);
        check_all_zero("init_reset");
        reset = 1'b0;
        step();
        check_all_zero("init_release");

        // Vector table: steady-state outputs after each hold
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].raw);
            repeat (vecs[i].hold) step();
            check($sformatf("vec%0d sel", i),     sel,     vecs[i].sel);
            check($sformatf("vec%0d adj", i),     adj,     vecs[i].adj);
            check($sformatf("vec%0d pause", i),   pause,   TOGGLE ? vecs[i].pause_tog : vecs[i].pause_lvl);
            check($sformatf("vec%0d rst_req", i), rst_req, vecs[i].rst_req);
        end

        // Reset mid-operation with inputs low (sel is 1 going in)
        drive(4'b0000);
        do_reset();
        step();
        check_all_zero("after_reset");

        // Switch latency: level accepted at edge 2+DEB
        drive(4'b1100);
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("lat sel e%0d", i), sel, (i >= 6));
            check($sformatf("lat adj e%0d", i), adj, (i >= 6));
        end
        drive(4'b0000);
        repeat (10) step();

        // Short reset press is filtered, long press yields one pulse at edge 3+DEB
        seen = 1'b0;
        drive(4'b0010);
        repeat (3) begin step(); seen |= rst_req; end
        drive(4'b0000);
        repeat (12) begin step(); seen |= rst_req; end
        check("short rst no pulse", seen, 1'b0);
        drive(4'b0010);
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("long rst e%0d", i), rst_req, (i == 7));
        end
        seen = 1'b0;
        drive(4'b0000);
        repeat (10) begin step(); seen |= rst_req; end
        check("rst release no pulse", seen, 1'b0);

        // Bouncing pause button, then stable press
        seen = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive((b % 2 == 0) ? 4'b0001 : 4'b0000);
            repeat (3) begin step(); seen |= pause; end
        end
        check("bounce no pause", seen, 1'b0);
        drive(4'b0001);
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("bounce run e%0d", i), pause, TOGGLE ? (i >= 7) : (i >= 6));
        end
        drive(4'b0000);
        repeat (10) step();
        check("pause after release", pause, TOGGLE);
        drive(4'b0001);
        repeat (10) step();
        drive(4'b0000);
        repeat (10) step();
        check("pause second press", pause, 1'b0);

        // Simultaneous pause and reset press while paused
        drive(4'b0001);
        repeat (10) step();
        drive(4'b0000);
        repeat (10) step();
        check("pre simul pause", pause, TOGGLE);
        drive(4'b0011);
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("simul rst_req e%0d", i), rst_req, (i == 7));
            if (i == 6) check("simul pause e6", pause, 1'b1);
            if (i == 7) check("simul pause e7", pause, ~TOGGLE);
        end
        drive(4'b0000);
        repeat (10) step();
        check("simul pause after release", pause, 1'b0);

        // Hold pause for 20 cycles, then release
        drive(4'b0001);
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("hold pause e%0d", i), pause, TOGGLE ? (i >= 7) : (i >= 6));
        end
        drive(4'b0000);
        for (int j = 1; j <= 10; j++) begin
            step();
            check($sformatf("hold release e%0d", j), pause, TOGGLE ? 1'b1 : (j < 6));
        end

        // Reset mid-debounce with sw_sel held high: count restarts from release
        drive(4'b0100);
        repeat (4) step();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("rst mid deb sel e%0d", i), sel, (i >= 6));
        end

        // Random stimulus against the reference model
        drive(4'b0000);
        do_reset();
        step();
        for (int n = 0; n < 3000; n++) begin
            check($sformatf("rand%0d sel", n),     sel,     m_db[2]);
            check($sformatf("rand%0d adj", n),     adj,     m_db[3]);
            check($sformatf("rand%0d pause", n),   pause,   m_pause);
            check($sformatf("rand%0d rst_req", n), rst_req, m_rst_req);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case (c)
                        0: btn_pause = ~btn_pause;
                        1: btn_rst   = ~btn_rst;
                        2: sw_sel    = ~sw_sel;
                        default: sw_adj = ~sw_adj;
                    endcase
                end
            end
            if (n == 1500) reset = 1'b1;
            if (n == 1503) reset = 1'b0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
